// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrgnt4.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__rrgnt4.sv - four-way round-robin grant distributor
// Holds one grant until ACK, owner drop or watchdog expiry, then rotates ownership.
module gf180mcu_fd_sc_mcu7t5v0__rrgnt4 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic ACK,
    output logic G1,
    output logic G2,
    output logic G3,
    output logic G4,
    output logic Z,
    output logic ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_LAST = 4'(HOLD_MAX - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_last,  w_last_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [3:0] r_g,     w_g_nxt;
    logic       r_z,     w_z_nxt;
    logic       r_err,   w_err_nxt;

    logic [3:0] w_req;
    logic       w_found;
    logic [1:0] w_pick;
    logic       w_owner_req;
    logic       w_timeout;

    assign w_req       = {A4, A3, A2, A1};
    assign w_owner_req = w_req[r_owner];
    assign w_timeout   = (r_cnt == C_CNT_LAST);

    // Pointers are 0-based (0..3 = requester 1..4); 2-bit adds wrap 4->1 for free.
    always_comb begin : arbiter
        logic [1:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_last;
        v_idx   = r_last;
        for (int i = 1; i <= 4; i++) begin
            v_idx = r_last + 2'(i);
            if (!w_found && w_req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_g_nxt     = r_g;
        w_z_nxt     = r_z;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_g_nxt     = 4'b0001 << w_pick;
                    w_z_nxt     = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_owner_nxt = w_pick;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (ACK || !w_owner_req || w_timeout) begin
                    w_g_nxt     = 4'b0000;
                    w_z_nxt     = 1'b0;
                    w_last_nxt  = r_owner;
                    w_state_nxt = RELEASE;
                    // ACK and owner drop both outrank the watchdog.
                    w_err_nxt   = !ACK && w_owner_req && w_timeout;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_g_nxt     = 4'b0000;
                w_z_nxt     = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_last  <= 2'd3;
            r_owner <= 2'd0;
            r_cnt   <= 4'd0;
            r_g     <= 4'b0000;
            r_z     <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_g     <= w_g_nxt;
            r_z     <= w_z_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign G1  = r_g[0];
    assign G2  = r_g[1];
    assign G3  = r_g[2];
    assign G4  = r_g[3];
    assign Z   = r_z;
    assign ERR = r_err;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrgnt4.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrgnt4.sv - directed bench for the round-robin grant distributor
module tb_gf180mcu_fd_sc_mcu7t5v0__rrgnt4;

    localparam int HM = 15;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic A1 = 1'b0, A2 = 1'b0, A3 = 1'b0, A4 = 1'b0;
    logic ACK = 1'b0;
    logic G1, G2, G3, G4, Z, ERR;

    int n_tests = 0;
    int n_fail  = 0;

    gf180mcu_fd_sc_mcu7t5v0__rrgnt4 #(.HOLD_MAX(HM)) dut (
        .CLK(CLK), .RST(RST),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .ACK(ACK),
        .G1(G1), .G2(G2), .G3(G3), .G4(G4),
        .Z(Z), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic       ack;
        logic [3:0] g;
        logic       z;
        logic       err;
    } vec_t;

    vec_t tbl[16];

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic rst, input logic [3:0] a, input logic ack,
                        input logic [3:0] eg, input logic ez, input logic eerr,
                        input string name);
        logic [5:0] act, exp;
        RST = rst;
        {A4, A3, A2, A1} = a;
        ACK = ack;
        @(negedge CLK);
        act = {G4, G3, G2, G1, Z, ERR};
        exp = {eg, ez, eerr};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got G4..G1,Z,ERR=%b required %b", name, act, exp);
        end
    endtask

    initial begin
        // Reset, then all four requesting with an ACK on every grant.
        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

        @(negedge CLK);
        for (int i = 0; i < 16; i++)
            step(tbl[i].rst, tbl[i].a, tbl[i].ack, tbl[i].g, tbl[i].z, tbl[i].err,
                 $sformatf("rr_vec%0d", i));

        // Only A3: ACK in third grant cycle, re-grant two cycles after release.
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "a3_reset");
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, $sformatf("a3_hold%0d", i));
        step(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, "a3_ack");
        step(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, "a3_release");
        step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, "a3_regrant");

        // Watchdog: A2 held, no ACK.
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "wd_reset");
        for (int i = 0; i < HM; i++)
            step(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, $sformatf("wd_hold%0d", i));
        step(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, "wd_err");
        step(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, "wd_release");
        step(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, "wd_next_g3");

        // ACK on the same edge the watchdog would fire.
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "ackto_reset");
        for (int i = 0; i < HM; i++)
            step(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, $sformatf("ackto_hold%0d", i));
        step(1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, "ackto_fall");
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "ackto_release");

        // Owner A4 abandons while A1 is requesting.
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "drop_reset");
        step(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0, "drop_g4");
        step(1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b0, "drop_nonowner_ignored");
        step(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, "drop_fall");
        step(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, "drop_release");
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, "drop_g1");

        // Reset mid-grant of G2 restores LAST=4.
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "rstg_reset");
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, "rstg_g2");
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, "rstg_g2_hold");
        step(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, "rstg_midgrant");
        step(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, "rstg_g1_wins");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
